alu_exec_unit: RTL and testbench

//  Consumer end of the RS->ALU issue interface. Accepts ready-to-run integer ops from the reservation

---
 rtl/alu_exec_unit.sv | 123 ++++++++++++
 tb/tb_alu_exec_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Integer ALU execution unit: buffers ops issued by the reservation station in a small FIFO,
// executes one per cycle and broadcasts {rob_id, value} on the ALU lane of the CDB.
module alu_exec_unit #(
  parameter int DEPTH = 4,
  parameter int ROB_W = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             _clear,
  input  logic             _alu_ready,
  input  logic [ROB_W-1:0] _alu_rob_id,
  input  logic [2:0]       _alu_op,
  input  logic             _alu_alt,
  input  logic             _alu_br,
  input  logic [31:0]      _alu_v1,
  input  logic [31:0]      _alu_v2,
  output logic             _alu_full,
  input  logic             _cdb_stall,
  output logic             _cdb_ready,
  output logic [ROB_W-1:0] _cdb_rob_id,
  output logic [31:0]      _cdb_value
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ROB_W-1:0] rob_id;
    logic [2:0]       op;
    logic             alt;
    logic             br;
    logic [31:0]      v1;
    logic [31:0]      v2;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // RV32I funct3 semantics; compare mode yields a zero-extended 0/1.
  function automatic logic [31:0] execute(input entry_t e);
    logic [31:0] r;
    logic        lt_s;
    logic        lt_u;
    lt_s = $signed(e.v1) < $signed(e.v2);
    lt_u = e.v1 < e.v2;
    r    = '0;
    if (e.br) begin
      case (e.op)
        3'd0:    r = {31'b0, e.v1 == e.v2};
        3'd1:    r = {31'b0, e.v1 != e.v2};
        3'd4:    r = {31'b0, lt_s};
        3'd5:    r = {31'b0, !lt_s};
        3'd6:    r = {31'b0, lt_u};
        3'd7:    r = {31'b0, !lt_u};
        default: r = '0;
      endcase
    end else begin
      case (e.op)
        3'd0:    r = e.alt ? e.v1 - e.v2 : e.v1 + e.v2;
        3'd1:    r = e.v1 << e.v2[4:0];
        3'd2:    r = {31'b0, lt_s};
        3'd3:    r = {31'b0, lt_u};
        3'd4:    r = e.v1 ^ e.v2;
        3'd5:    r = e.alt ? 32'($signed(e.v1) >>> e.v2[4:0]) : e.v1 >> e.v2[4:0];
        3'd6:    r = e.v1 | e.v2;
        default: r = e.v1 & e.v2;
      endcase
    end
    return r;
  endfunction

  assign head      = mem[rptr];
  assign _alu_full = rdy_in && !_clear && (count < CNT_W'(DEPTH));
  assign push      = _alu_ready && _alu_full;
  // A stalled broadcast may only be replaced once the consumer has taken it.
  assign pop       = rdy_in && !_clear && (count != '0) && (!_cdb_ready || !_cdb_stall);

  // NOTE: payload storage is deliberately not reset; count decides which slots are live.
  always_ff @(posedge clk_in) begin
    if (push) mem[wptr] <= '{rob_id: _alu_rob_id, op: _alu_op, alt: _alu_alt,
                             br: _alu_br, v1: _alu_v1, v2: _alu_v2};
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      count       <= '0;
      wptr        <= '0;
      rptr        <= '0;
      _cdb_ready  <= 1'b0;
      _cdb_rob_id <= '0;
      _cdb_value  <= '0;
    end else if (rdy_in) begin
      if (_clear) begin
        count      <= '0;
        wptr       <= '0;
        rptr       <= '0;
        _cdb_ready <= 1'b0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (pop) begin
          _cdb_ready  <= 1'b1;
          _cdb_rob_id <= head.rob_id;
          _cdb_value  <= execute(head);
        end else if (_cdb_ready && !_cdb_stall) begin
          _cdb_ready <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized traffic scored
// against a queue-based behavioural model of the issue FIFO and CDB broadcast.
module tb_alu_exec_unit;

  localparam int DEPTH = 4;
  localparam int ROB_W = 5;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             rdy_in;
  logic             _clear;
  logic             _alu_ready;
  logic [ROB_W-1:0] _alu_rob_id;
  logic [2:0]       _alu_op;
  logic             _alu_alt;
  logic             _alu_br;
  logic [31:0]      _alu_v1;
  logic [31:0]      _alu_v2;
  logic             _alu_full;
  logic             _cdb_stall;
  logic             _cdb_ready;
  logic [ROB_W-1:0] _cdb_rob_id;
  logic [31:0]      _cdb_value;

  alu_exec_unit #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(_clear),
    ._alu_ready(_alu_ready), ._alu_rob_id(_alu_rob_id), ._alu_op(_alu_op),
    ._alu_alt(_alu_alt), ._alu_br(_alu_br), ._alu_v1(_alu_v1), ._alu_v2(_alu_v2),
    ._alu_full(_alu_full), ._cdb_stall(_cdb_stall), ._cdb_ready(_cdb_ready),
    ._cdb_rob_id(_cdb_rob_id), ._cdb_value(_cdb_value)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Behavioural model: queue of issued results plus the visible broadcast.
  typedef struct {
    logic [ROB_W-1:0] rob;
    logic [31:0]      val;
  } result_t;

  result_t          q[$];
  logic             m_valid = 1'b0;
  logic [ROB_W-1:0] m_rob   = '0;
  logic [31:0]      m_val   = '0;
  logic             exp_full;
  logic             obs_full;

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic alt,
                                             input logic br, input logic [31:0] v1,
                                             input logic [31:0] v2);
    int signed       s1 = v1;
    int signed       s2 = v2;
    longint unsigned u1 = v1;
    longint unsigned u2 = v2;
    int              sh = int'(v2 % 32);
    if (br) begin
      case (op)
        3'd0:    return (v1 == v2) ? 1 : 0;
        3'd1:    return (v1 != v2) ? 1 : 0;
        3'd4:    return (s1 < s2) ? 1 : 0;
        3'd5:    return (s1 >= s2) ? 1 : 0;
        3'd6:    return (u1 < u2) ? 1 : 0;
        3'd7:    return (u1 >= u2) ? 1 : 0;
        default: return 0;
      endcase
    end
    case (op)
      3'd0:    return alt ? v1 - v2 : v1 + v2;
      3'd1:    return v1 << sh;
      3'd2:    return (s1 < s2) ? 1 : 0;
      3'd3:    return (u1 < u2) ? 1 : 0;
      3'd4:    return v1 ^ v2;
      3'd5:    return alt ? 32'(s1 >>> sh) : v1 >> sh;
      3'd6:    return v1 | v2;
      default: return v1 & v2;
    endcase
  endfunction

  task automatic idle_inputs();
    rst_in = 1'b1; rdy_in = 1'b1; _clear = 1'b0; _alu_ready = 1'b0; _cdb_stall = 1'b0;
    _alu_rob_id = '0; _alu_op = '0; _alu_alt = 1'b0; _alu_br = 1'b0;
    _alu_v1 = '0; _alu_v2 = '0;
  endtask

  task automatic set_op(input logic [ROB_W-1:0] rob, input logic [2:0] op, input logic alt,
                        input logic br, input logic [31:0] v1, input logic [31:0] v2);
    _alu_ready = 1'b1; _alu_rob_id = rob; _alu_op = op; _alu_alt = alt; _alu_br = br;
    _alu_v1 = v1; _alu_v2 = v2;
  endtask

  // One clock: sample _alu_full before the edge, advance the model at the edge.
  task automatic cycle();
    bit      do_push;
    bit      do_pop;
    result_t r;
    #1;
    exp_full = rdy_in && !_clear && (q.size() < DEPTH);
    obs_full = _alu_full;
    @(posedge clk_in);
    if (!rst_in) begin
      q.delete(); m_valid = 1'b0; m_rob = '0; m_val = '0;
    end else if (rdy_in) begin
      if (_clear) begin
        q.delete(); m_valid = 1'b0;
      end else begin
        do_push = _alu_ready && (q.size() < DEPTH);
        do_pop  = (q.size() > 0) && (!m_valid || !_cdb_stall);
        if (do_pop) begin
          r = q.pop_front(); m_valid = 1'b1; m_rob = r.rob; m_val = r.val;
        end else if (m_valid && !_cdb_stall) begin
          m_valid = 1'b0;
        end
        if (do_push) begin
          r.rob = _alu_rob_id;
          r.val = ref_result(_alu_op, _alu_alt, _alu_br, _alu_v1, _alu_v2);
          q.push_back(r);
        end
      end
    end
    @(negedge clk_in);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom();
    endcase
  endfunction

  task automatic rand_op();
    set_op(ROB_W'($urandom()), 3'($urandom()), 1'($urandom()), ($urandom_range(0, 3) == 0),
           rand_operand(), rand_operand());
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_in = 1'b0;
    cycle();
    cycle();
    total++;
    if (_cdb_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", _cdb_ready); end
    total++;
    if (_cdb_rob_id !== '0) begin bad++; $display("FAIL reset_rob got=%0d want=0", _cdb_rob_id); end
    total++;
    if (_cdb_value !== 32'h0) begin bad++; $display("FAIL reset_value got=%h want=0", _cdb_value); end
    rst_in = 1'b1;
    cycle();
    total++;
    if (obs_full !== 1'b1) begin bad++; $display("FAIL reset_full got=%b want=1", obs_full); end
  endtask

  task automatic run_single(input logic [ROB_W-1:0] rob, input logic [2:0] op, input logic alt,
                            input logic br, input logic [31:0] v1, input logic [31:0] v2,
                            input logic [31:0] want, input string name);
    set_op(rob, op, alt, br, v1, v2);
    cycle();
    _alu_ready = 1'b0;
    total++;
    if (_cdb_ready !== 1'b0) begin bad++; $display("FAIL %s_latency ready=%b want=0", name, _cdb_ready); end
    cycle();
    total++;
    if (_cdb_ready !== 1'b1 || _cdb_rob_id !== rob || _cdb_value !== want) begin
      bad++;
      $display("FAIL %s got ready=%b rob=%0d value=%h want ready=1 rob=%0d value=%h",
               name, _cdb_ready, _cdb_rob_id, _cdb_value, rob, want);
    end
    cycle();
    total++;
    if (_cdb_ready !== 1'b0) begin bad++; $display("FAIL %s_drop ready=%b want=0", name, _cdb_ready); end
  endtask

  task automatic test_directed_ops();
    idle_inputs();
    run_single(5'd3, 3'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, "add");
    run_single(5'd4, 3'd0, 1'b1, 1'b0, 32'd0, 32'd1, 32'hFFFF_FFFF, "sub");
    run_single(5'd5, 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra");
    run_single(5'd6, 3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, "srl");
    run_single(5'd7, 3'd3, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd1, "sltu");
    run_single(5'd8, 3'd4, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1, "blt");
    run_single(5'd9, 3'd7, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1, "bgeu");
    run_single(5'd10, 3'd2, 1'b0, 1'b1, 32'd1, 32'd2, 32'd0, "br_op2");
    run_single(5'd11, 3'd1, 1'b0, 1'b0, 32'd1, 32'd33, 32'd2, "sll_mask");
    run_single(5'd12, 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd1, "slt");
  endtask

  task automatic test_stall_backpressure();
    int accepted = 0;
    int seen = 0;
    idle_inputs();
    _cdb_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_op();
      _alu_rob_id = ROB_W'(16 + i);
      cycle();
      if (obs_full) accepted++;
      total++;
      if (obs_full !== exp_full) begin bad++; $display("FAIL stall_full[%0d] got=%b want=%b", i, obs_full, exp_full); end
    end
    total++;
    if (accepted !== 5) begin bad++; $display("FAIL stall_accept_count got=%0d want=5", accepted); end
    idle_inputs();
    for (int i = 0; i < 7; i++) begin
      if (_cdb_ready) seen++;
      total++;
      if (_cdb_ready !== m_valid || (m_valid && (_cdb_rob_id !== m_rob || _cdb_value !== m_val))) begin
        bad++;
        $display("FAIL stall_drain[%0d] got ready=%b rob=%0d value=%h want ready=%b rob=%0d value=%h",
                 i, _cdb_ready, _cdb_rob_id, _cdb_value, m_valid, m_rob, m_val);
      end
      cycle();
    end
    total++;
    if (seen !== 5) begin bad++; $display("FAIL stall_result_count got=%0d want=5", seen); end
  endtask

  task automatic test_push_pop_same_edge();
    idle_inputs();
    _cdb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_op(ROB_W'(i), 3'd0, 1'b0, 1'b0, 32'(100 * i), 32'd1);
      cycle();
    end
    _cdb_stall = 1'b0;
    set_op(5'd4, 3'd0, 1'b0, 1'b0, 32'd400, 32'd1);
    cycle();
    total++;
    if (obs_full !== 1'b1) begin bad++; $display("FAIL pp_full_before got=%b want=1", obs_full); end
    _alu_ready = 1'b0;
    _cdb_stall = 1'b1;
    cycle();
    total++;
    if (obs_full !== 1'b1) begin bad++; $display("FAIL pp_full_after got=%b want=1", obs_full); end
    set_op(5'd5, 3'd0, 1'b0, 1'b0, 32'd500, 32'd1);
    cycle();
    _alu_ready = 1'b0;
    cycle();
    total++;
    if (obs_full !== 1'b0) begin bad++; $display("FAIL pp_full_at_depth got=%b want=0", obs_full); end
    _cdb_stall = 1'b0;
    for (int i = 0; i < 7; i++) begin
      total++;
      if (_cdb_ready !== m_valid || (m_valid && (_cdb_rob_id !== m_rob || _cdb_value !== m_val))) begin
        bad++;
        $display("FAIL pp_drain[%0d] got ready=%b rob=%0d value=%h want ready=%b rob=%0d value=%h",
                 i, _cdb_ready, _cdb_rob_id, _cdb_value, m_valid, m_rob, m_val);
      end
      cycle();
    end
  endtask

  task automatic test_clear();
    idle_inputs();
    _cdb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_op(ROB_W'(20 + i), 3'd6, 1'b0, 1'b0, 32'(i), 32'h100);
      cycle();
    end
    _clear = 1'b1;
    set_op(5'd30, 3'd0, 1'b0, 1'b0, 32'd1, 32'd1);
    cycle();
    total++;
    if (obs_full !== 1'b0) begin bad++; $display("FAIL clear_full_during got=%b want=0", obs_full); end
    idle_inputs();
    total++;
    if (_cdb_ready !== 1'b0) begin bad++; $display("FAIL clear_ready got=%b want=0", _cdb_ready); end
    for (int i = 0; i < 5; i++) begin
      cycle();
      total++;
      if (_cdb_ready !== 1'b0 || obs_full !== 1'b1) begin
        bad++;
        $display("FAIL clear_stale[%0d] got ready=%b full=%b want ready=0 full=1", i, _cdb_ready, obs_full);
      end
    end
    run_single(5'd31, 3'd7, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, "post_clear");
  endtask

  task automatic test_pause_and_reset();
    idle_inputs();
    for (int i = 0; i < 14; i++) begin
      rand_op();
      _cdb_stall = ($urandom_range(0, 3) == 0);
      rdy_in     = !(i >= 4 && i < 7);
      cycle();
      total++;
      if (obs_full !== exp_full) begin bad++; $display("FAIL pause_full[%0d] got=%b want=%b", i, obs_full, exp_full); end
      total++;
      if (_cdb_ready !== m_valid || (m_valid && (_cdb_rob_id !== m_rob || _cdb_value !== m_val))) begin
        bad++;
        $display("FAIL pause_out[%0d] got ready=%b rob=%0d value=%h want ready=%b rob=%0d value=%h",
                 i, _cdb_ready, _cdb_rob_id, _cdb_value, m_valid, m_rob, m_val);
      end
    end
    rst_in = 1'b0;
    rand_op();
    cycle();
    total++;
    if (_cdb_ready !== 1'b0 || _cdb_rob_id !== '0 || _cdb_value !== 32'h0) begin
      bad++;
      $display("FAIL midreset got ready=%b rob=%0d value=%h want all zero", _cdb_ready, _cdb_rob_id, _cdb_value);
    end
    idle_inputs();
    cycle();
    cycle();
    total++;
    if (_cdb_ready !== 1'b0 || obs_full !== 1'b1) begin
      bad++;
      $display("FAIL midreset_after got ready=%b full=%b want ready=0 full=1", _cdb_ready, obs_full);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) rand_op(); else _alu_ready = 1'b0;
      _cdb_stall = ($urandom_range(0, 3) == 0);
      rdy_in     = ($urandom_range(0, 9) != 0);
      _clear     = ($urandom_range(0, 49) == 0);
      cycle();
      total++;
      if (obs_full !== exp_full) begin bad++; $display("FAIL rand_full[%0d] got=%b want=%b", i, obs_full, exp_full); end
      total++;
      if (_cdb_ready !== m_valid || (m_valid && (_cdb_rob_id !== m_rob || _cdb_value !== m_val))) begin
        bad++;
        $display("FAIL rand_out[%0d] got ready=%b rob=%0d value=%h want ready=%b rob=%0d value=%h",
                 i, _cdb_ready, _cdb_rob_id, _cdb_value, m_valid, m_rob, m_val);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_directed_ops();
    test_stall_backpressure();
    test_push_pop_same_edge();
    test_clear();
    test_pause_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
